// File: rtl/fancytimer_sched.sv
// fancytimer_sched
//   Round-robin scheduler that shares one pattern-triggered delay timer among
//   NUM_REQ requesters. The winning requester's 4-bit delay is serialized to
//   the timer as 1101 followed by d3..d0. The timer's done flag is routed back
//   to the owner, and the owner's ack is relayed to the timer.
//
//   Build option: define FANCYTIMER_SCHED_FIXED_PRIO_EN to make the lowest
//   indexed request always win. This build has no round-robin pointer.
//   Round-robin arbitration is the default.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high (shared with the timer)
//   req         per-requester request level, held until grant
//   delay_in    per-requester 4-bit delay, slice i = [4i+3:4i]
//   grant       one-cycle one-hot grant pulse (first SEND cycle)
//   done_out    one-hot, owner's timer expired and not yet acknowledged
//   ack_in      per-requester acknowledge (only the owner's bit is used)
//   busy        high in every state except IDLE
//   owner       index of current / last owner
//   timer_data  serial start pattern to the timer
//   timer_done  timer expiry flag
//   timer_ack   one-cycle acknowledge to the timer
module fancytimer_sched #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   delay_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done_out,
  input  logic [NUM_REQ-1:0]     ack_in,
  output logic                   busy,
  output logic [OWN_W-1:0]       owner,
  output logic                   timer_data,
  input  logic                   timer_done,
  output logic                   timer_ack
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RUN,
    NOTIFY,
    RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bitCnt_q, bitCnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 timerData_q, timerData_d;
  logic                 timerAck_q, timerAck_d;

`ifndef FANCYTIMER_SCHED_FIXED_PRIO_EN
  // Last owner; resets to NUM_REQ-1 so index 0 is searched first.
  logic [OWN_W-1:0]     rrPtr_q, rrPtr_d;
`endif

  logic                 anyReq;
  logic                 found;
  logic [OWN_W-1:0]     winner;
  logic [3:0]           selDelay;
  logic [NUM_REQ-1:0]   winnerOneHot;
  logic [NUM_REQ-1:0]   ownerOneHot;
  logic                 ackOwner;

  // Arbitration. Index comparisons against loop constants avoid a
  // variable-width bit select into req.
  always_comb begin
    anyReq   = |req;
    found    = 1'b0;
    winner   = '0;
    selDelay = 4'd0;
`ifdef FANCYTIMER_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = OWN_W'(i);
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(rrPtr_q) + k) % NUM_REQ) == i)) begin
          found  = 1'b1;
          winner = OWN_W'(i);
        end
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == OWN_W'(i)) begin
        selDelay = delay_in[4*i +: 4];
      end
    end
  end

  assign winnerOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign ownerOneHot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign ackOwner     = |(ack_in & ownerOneHot);

  // State register and all output / datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      shift_q     <= 8'd0;
      bitCnt_q    <= 3'd0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      timerData_q <= 1'b0;
      timerAck_q  <= 1'b0;
`ifndef FANCYTIMER_SCHED_FIXED_PRIO_EN
      rrPtr_q     <= OWN_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      timerData_q <= timerData_d;
      timerAck_q  <= timerAck_d;
`ifndef FANCYTIMER_SCHED_FIXED_PRIO_EN
      rrPtr_q     <= rrPtr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq)           state_d = SEND;
      SEND:    if (bitCnt_q == 3'd7) state_d = RUN;
      RUN:     if (timer_done)       state_d = NOTIFY;
      NOTIFY:  if (ackOwner)         state_d = RELEASE;
      RELEASE:                       state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output logic. Outputs are computed one cycle ahead so every port is a
  // plain flop: the first pattern bit is launched on the IDLE->SEND edge and
  // the shift register holds the remaining seven.
  always_comb begin
    owner_d     = owner_q;
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    grant_d     = '0;
    done_d      = '0;
    busy_d      = (state_d != IDLE);
    timerData_d = 1'b0;
    timerAck_d  = 1'b0;
`ifndef FANCYTIMER_SCHED_FIXED_PRIO_EN
    rrPtr_d     = rrPtr_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d     = winner;
          grant_d     = winnerOneHot;
          timerData_d = 1'b1;
          shift_d     = {3'b101, selDelay, 1'b0};
          bitCnt_d    = 3'd0;
`ifndef FANCYTIMER_SCHED_FIXED_PRIO_EN
          rrPtr_d     = winner;
`endif
        end
      end
      SEND: begin
        if (bitCnt_q != 3'd7) begin
          timerData_d = shift_q[7];
          shift_d     = {shift_q[6:0], 1'b0};
          bitCnt_d    = bitCnt_q + 3'd1;
        end
      end
      RUN: begin
        if (timer_done) begin
          done_d = ownerOneHot;
        end
      end
      NOTIFY: begin
        if (ackOwner) begin
          timerAck_d = 1'b1;
        end else begin
          done_d = ownerOneHot;
        end
      end
      default: begin
      end
    endcase
  end

  assign grant      = grant_q;
  assign done_out   = done_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign timer_data = timerData_q;
  assign timer_ack  = timerAck_q;

endmodule

// File: tb/tb_fancytimer_sched.sv
// tb_fancytimer_sched
//   Directed bench for fancytimer_sched with a behavioural model of the shared
//   delay timer (detects 1101, loads 4 delay bits, counts (d+1)*1000 cycles,
//   holds done until timer_ack).
module tb_fancytimer_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] delayIn;
  logic [3:0]  grant;
  logic [3:0]  doneOut;
  logic [3:0]  ackIn;
  logic        busy;
  logic [1:0]  owner;
  logic        timerData;
  logic        timerDone;
  logic        timerAck;

  int checks = 0;
  int errors = 0;

  fancytimer_sched #(.NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .delay_in   (delayIn),
    .grant      (grant),
    .done_out   (doneOut),
    .ack_in     (ackIn),
    .busy       (busy),
    .owner      (owner),
    .timer_data (timerData),
    .timer_done (timerDone),
    .timer_ack  (timerAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural timer sharing the scheduler's reset
  typedef enum logic [1:0] {T_SEARCH, T_LOAD, T_COUNT, T_DONE} tState_t;
  tState_t    tState;
  logic [2:0] hist;
  logic [3:0] dly;
  logic [1:0] nBits;
  int         cnt;

  always @(posedge clk) begin
    if (reset) begin
      tState    <= T_SEARCH;
      hist      <= 3'd0;
      dly       <= 4'd0;
      nBits     <= 2'd0;
      cnt       <= 0;
      timerDone <= 1'b0;
    end else begin
      case (tState)
        T_SEARCH: begin
          if ({hist, timerData} == 4'b1101) begin
            tState <= T_LOAD;
            hist   <= 3'd0;
            nBits  <= 2'd0;
          end else begin
            hist <= {hist[1:0], timerData};
          end
        end
        T_LOAD: begin
          dly   <= {dly[2:0], timerData};
          nBits <= nBits + 2'd1;
          if (nBits == 2'd3) begin
            tState <= T_COUNT;
            cnt    <= (int'({dly[2:0], timerData}) + 1) * 1000;
          end
        end
        T_COUNT: begin
          if (cnt == 1) begin
            timerDone <= 1'b1;
            tState    <= T_DONE;
          end else begin
            cnt <= cnt - 1;
          end
        end
        T_DONE: begin
          if (timerAck) begin
            timerDone <= 1'b0;
            tState    <= T_SEARCH;
          end
        end
        default: tState <= T_SEARCH;
      endcase
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d, input logic [3:0] a);
    req     = r;
    delayIn = d;
    ackIn   = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called in the first SEND cycle; returns in the last SEND cycle.
  task automatic collectBits(input string tag, output logic [7:0] bits);
    bits = 8'd0;
    for (int k = 0; k < 8; k++) begin
      bits = {bits[6:0], timerData};
      if (k == 1) checkOutput({tag, " grant pulse width"}, 32'(grant), 32'h0);
      if (k < 7) tick();
    end
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (doneOut == 4'b0000 && cycles < 20000) begin
      tick();
      cycles++;
    end
  endtask

  task automatic waitGrant();
    int n = 0;
    while (grant == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic finishJob(input string tag, input logic [3:0] oh);
    ackIn = oh;
    tick();
    checkOutput({tag, " timer_ack"}, 32'(timerAck), 32'h1);
    checkOutput({tag, " done cleared"}, 32'(doneOut), 32'h0);
    ackIn = 4'b0000;
    tick();
    checkOutput({tag, " ack width"}, 32'(timerAck), 32'h0);
    checkOutput({tag, " idle busy"}, 32'(busy), 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " grant"}, 32'(grant), 32'h0);
    checkOutput({tag, " done"}, 32'(doneOut), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " owner"}, 32'(owner), 32'h0);
    checkOutput({tag, " timer_data"}, 32'(timerData), 32'h0);
    checkOutput({tag, " timer_ack"}, 32'(timerAck), 32'h0);
  endtask

  initial begin
    logic [7:0] bits;
    int         cyc;
    int         n;
    logic [3:0] expOh;

    reset = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 4'b0000);
    tick();
    tick();
    checkResetOutputs("reset");
    reset = 1'b0;

    // Single request, delay 0
    applyStimulus(4'b0010, 16'h0000, 4'b0000);
    tick();
    checkOutput("t1 grant", 32'(grant), 32'h2);
    checkOutput("t1 owner", 32'(owner), 32'h1);
    checkOutput("t1 busy", 32'(busy), 32'h1);
    applyStimulus(4'b0000, 16'h0000, 4'b0000);
    collectBits("t1", bits);
    checkOutput("t1 bits", 32'(bits), 32'hD0);
    n = 0;
    while (!timerDone && n < 20000) begin
      tick();
      n++;
    end
    checkOutput("t1 done before relay", 32'(doneOut), 32'h0);
    tick();
    checkOutput("t1 done relay", 32'(doneOut), 32'h2);
    finishJob("t1", 4'b0010);

    // Delay capture: A captured, then delay_in changed to 3
    applyStimulus(4'b0100, 16'h0A00, 4'b0000);
    tick();
    checkOutput("t2 grant", 32'(grant), 32'h4);
    applyStimulus(4'b0000, 16'h0300, 4'b0000);
    collectBits("t2", bits);
    checkOutput("t2 bits", 32'(bits), 32'hDA);
    waitDone(cyc);
    checkOutput("t2 grant to done cycles", 32'(cyc + 7), 32'd11009);
    checkOutput("t2 done", 32'(doneOut), 32'h4);
    finishJob("t2", 4'b0100);

    // Fairness from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b1111, 16'h0000, 4'b0000);
    for (int j = 0; j < 5; j++) begin
`ifdef FANCYTIMER_SCHED_FIXED_PRIO_EN
      expOh = 4'b0001;
`else
      expOh = 4'b0001 << (j % 4);
`endif
      waitGrant();
      checkOutput($sformatf("rr grant %0d", j), 32'(grant), 32'(expOh));
      waitDone(cyc);
      checkOutput($sformatf("rr done %0d", j), 32'(doneOut), 32'(expOh));
      finishJob($sformatf("rr job %0d", j), expOh);
    end
    req = 4'b0000;

    // Wrong-index ack is ignored
    applyStimulus(4'b0100, 16'h0000, 4'b0000);
    tick();
    checkOutput("wa grant", 32'(grant), 32'h4);
    req = 4'b0000;
    waitDone(cyc);
    checkOutput("wa done", 32'(doneOut), 32'h4);
    ackIn = 4'b0001;
    tick();
    checkOutput("wa no timer_ack", 32'(timerAck), 32'h0);
    checkOutput("wa done held", 32'(doneOut), 32'h4);
    tick();
    checkOutput("wa done held 2", 32'(doneOut), 32'h4);
    checkOutput("wa busy", 32'(busy), 32'h1);
    finishJob("wa", 4'b0100);

    // Reset during SEND at bit 3
    applyStimulus(4'b0010, 16'h0000, 4'b0000);
    tick();
    checkOutput("rs grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    tick();
    tick();
    checkOutput("rs bit3", 32'(timerData), 32'h1);
    reset = 1'b1;
    tick();
    checkResetOutputs("rs");
    reset = 1'b0;
    applyStimulus(4'b1000, 16'h0000, 4'b0000);
    tick();
    checkOutput("rs new grant", 32'(grant), 32'h8);
    checkOutput("rs new owner", 32'(owner), 32'h3);
    req = 4'b0000;
    collectBits("rs", bits);
    checkOutput("rs bits", 32'(bits), 32'hD0);
    waitDone(cyc);
    checkOutput("rs done", 32'(doneOut), 32'h8);
    finishJob("rs", 4'b1000);

    // Back-to-back: req[0] held, req[1] pending
    applyStimulus(4'b0001, 16'h0000, 4'b0000);
    tick();
    checkOutput("bb grant0", 32'(grant), 32'h1);
    req = 4'b0011;
    collectBits("bb0", bits);
    checkOutput("bb0 bits", 32'(bits), 32'hD0);
    waitDone(cyc);
    checkOutput("bb0 done", 32'(doneOut), 32'h1);
    ackIn = 4'b0001;
    tick();
    checkOutput("bb timer_ack", 32'(timerAck), 32'h1);
    checkOutput("bb gap data 0", 32'(timerData), 32'h0);
    ackIn = 4'b0000;
    tick();
    checkOutput("bb idle busy", 32'(busy), 32'h0);
    checkOutput("bb gap data 1", 32'(timerData), 32'h0);
    tick();
`ifdef FANCYTIMER_SCHED_FIXED_PRIO_EN
    expOh = 4'b0001;
`else
    expOh = 4'b0010;
`endif
    checkOutput("bb grant1", 32'(grant), 32'(expOh));
    req = 4'b0000;
    collectBits("bb1", bits);
    checkOutput("bb1 bits", 32'(bits), 32'hD0);
    waitDone(cyc);
    checkOutput("bb1 done", 32'(doneOut), 32'(expOh));
    finishJob("bb1", expOh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fancytimer_sched.md
Name: fancytimer_sched

Overview:
- Round-robin scheduler that shares one pattern-triggered delay timer among NUM_REQ requesters.
- The timer is started by serial pattern 1101, followed by 4 delay bits MSB-first. It counts (delay+1)*1000 cycles, raises done, then waits for ack.
- This block arbitrates requests and serializes the start sequence onto the timer data line. It routes done back to the winning requester and relays that requester's ack to the timer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- OWN_W, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high. The shared timer is driven by the same reset.
- req  input  NUM_REQ  per-requester request level. Held by the requester until its grant pulse.
- delay_in  input  4*NUM_REQ  per-requester 4-bit delay; slice i is bits [4i+3:4i].
- grant  output  NUM_REQ  one-cycle one-hot pulse when a request is accepted.
- done_out  output  NUM_REQ  one-hot; high while the owner's timer has expired and is unacknowledged.
- ack_in  input  NUM_REQ  per-requester acknowledge. Only ack_in[owner] is observed, and only in NOTIFY.
- busy  output  1  high in every state except IDLE.
- owner  output  OWN_W  index of the current owner; holds its last value while IDLE.
- timer_data  output  1  serial data to the timer.
- timer_done  input  1  timer expiry flag.
- timer_ack  output  1  acknowledge to the timer.

Behaviour:
- Reset values: state=IDLE, grant=0, done_out=0, busy=0, owner=0, timer_data=0, timer_ack=0. The round-robin pointer resets so that index 0 has the highest priority.
- Reset mid-operation aborts immediately, with no grant, done or ack emitted. The timer is reset by the same reset, so the two stay aligned.
- All outputs are registered.
- IDLE:
  - timer_data=0.
  - If any req bit is set, pick the winner: the first set bit searching upward from (last_owner+1) mod NUM_REQ, wrapping.
  - On that edge: latch owner, latch delay_in slice[owner] into shift register {1,1,0,1,d3,d2,d1,d0}, clear bit counter, go to SEND.
  - grant[owner]=1 for exactly the first SEND cycle.
- SEND:
  - timer_data = MSB of the shift register; shift left one bit per cycle.
  - Exactly 8 cycles, bit counter 0..7, then go to RUN.
  - The requester may change delay_in after grant; the captured value is used.
- RUN:
  - timer_data=0.
  - Wait for timer_done=1, then go to NOTIFY.
  - There is no timeout; the block stays in RUN indefinitely.
- NOTIFY:
  - done_out[owner]=1 (all other bits 0).
  - When ack_in[owner]=1, go to RELEASE. ack_in on other indices is ignored.
  - ack_in[owner] already high on NOTIFY entry is accepted on the first NOTIFY cycle.
- RELEASE:
  - timer_ack=1 for exactly one cycle; done_out=0; go to IDLE.
  - The timer returns to its search state on this edge, so the next SEND may start two cycles later without a false pattern.
- Requests arriving while busy are held pending, not lost, provided req stays high. req from the current owner is ignored until IDLE.
- Round-robin pointer = last owner. A requester that re-asserts req immediately is served after all other pending requesters.
- All NUM_REQ requesting continuously: grants rotate 0,1,2,...,NUM_REQ-1,0.
- Minimum cycles from grant pulse to done_out rise: 8 (SEND) + timer latency + 1.
- delay_in values 0..15 are all legal; 15 yields a 16000-cycle count. No width arithmetic is performed on delay in this block.

Optional Feature:
- FANCYTIMER_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-indexed set req bit always wins, and the round-robin pointer is removed.
- Undefined: round-robin as above (default).
- All other timing is identical in both modes.

Test Plan:
- Single request, round-robin mode:
  - req[1]=1 with delay_in[7:4]=4'h0, using the behavioural timer model.
  - grant=4'b0010 for one cycle.
  - timer_data sequence over the next 8 cycles = 1,1,0,1,0,0,0,0.
  - done_out[1] rises 1 cycle after timer_done rises.
  - ack_in[1] -> timer_ack 1-cycle pulse next cycle; busy=0 the cycle after.
- Delay capture: req[2]=1 with delay 4'hA, delay_in changed to 4'h3 right after grant -> serialized bits 1,1,0,1,1,0,1,0 and timer count = 11000 cycles.
- Round-robin fairness: req=4'b1111 held, each done acked immediately -> grant order 0,1,2,3,0. Fixed-prio build: grant always 0.
- Wrong ack: in NOTIFY with owner=2, pulse ack_in[0] -> no timer_ack, done_out stays 4'b0100. Then ack_in[2] -> RELEASE.
- Reset mid-SEND: assert reset at bit 3 -> next cycle all outputs 0 and state IDLE. A new req[3] afterwards gets a clean 8-bit pattern.
- Back-to-back: req[0] is held through completion while req[1] is pending -> second grant goes to 1. Its SEND starts 2 cycles after the timer_ack pulse, and timer_data stays 0 between the two sequences.
